// File: rtl/cnt_dwn_ctrl.sv
// rtl/cnt_dwn_ctrl.sv - load/prescale/decrement sequencer for an external 4-bit down-counter
// Optional: CNT_DWN_CTRL_RELOAD_EN reloads the held value on every zero and keeps running until abort.
module cnt_dwn_ctrl #(
  parameter int DIV   = 4,
  parameter int DIV_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_val,
  input  logic       abort,
  output logic [3:0] cnt_in,
  output logic       cnt_latch,
  output logic       cnt_dec,
  input  logic       cnt_zero,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [DIV_W-1:0] LP_PRESC_LAST = DIV_W'(DIV - 1);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_val;
  logic [DIV_W-1:0] r_presc;
  logic             w_presc_last;

  assign w_presc_last = (r_presc == LP_PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // abort outranks zero-detect in RUN
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = S_LOAD;
      S_LOAD: w_next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)         w_next = S_IDLE;
`ifdef CNT_DWN_CTRL_RELOAD_EN
        else if (cnt_zero) w_next = S_LOAD;
`else
        else if (cnt_zero) w_next = S_DONE;
`endif
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val   <= 4'd0;
      r_presc <= '0;
    end else begin
      if (r_state == S_IDLE && req_valid) r_val <= req_val;
      if (r_state == S_LOAD)
        r_presc <= '0;
      else if (r_state == S_RUN)
        r_presc <= w_presc_last ? '0 : r_presc + DIV_W'(1);
    end
  end

`ifdef CNT_DWN_CTRL_RELOAD_EN
  // marks a LOAD entered from RUN so the reload cycle doubles as the done pulse
  logic r_reload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      r_reload <= 1'b0;
    else if (r_state == S_RUN && w_next == S_LOAD) r_reload <= 1'b1;
    else if (r_state == S_IDLE)                   r_reload <= 1'b0;
  end
`endif

  always_comb begin
    req_ready = (r_state == S_IDLE);
    cnt_in    = r_val;
    cnt_latch = (r_state == S_LOAD);
    cnt_dec   = (r_state == S_RUN) && w_presc_last && !cnt_zero && !abort;
    busy      = (r_state == S_LOAD) || (r_state == S_RUN);
`ifdef CNT_DWN_CTRL_RELOAD_EN
    done      = (r_state == S_LOAD) && r_reload;
`else
    done      = (r_state == S_DONE);
`endif
  end

endmodule
